// File: rtl/bit_array_pkg.sv
// Shared definitions for the bit-array controller.
//   state_e   : controller FSM states (CLEAR sweeps the array, IDLE serves requests)
//   wr_req_t  : one write request (valid, address, data)
//   DEPTH_DEF / ADDR_W_DEF : default array geometry
package bit_array_pkg;

  localparam int DEPTH_DEF  = 256;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_W_DEF-1:0] addr;
    logic                  data;
  } wr_req_t;

endpackage

// File: rtl/bit_array_sweep.sv
// Clear-sweep counter for the bit array.
//   clock, reset : clock and asynchronous active-high reset
//   active       : sweep is running (controller in CLEAR)
//   restart      : force the pointer back to 0 for the next cycle
//   ptr          : address being cleared this cycle
//   done         : last address is being cleared this cycle
module bit_array_sweep
  import bit_array_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              active,
  input  logic              restart,
  output logic [ADDR_W-1:0] ptr,
  output logic              done
);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              last;

  assign last = (ptr_q == ADDR_W'(DEPTH - 1));

  // The pointer parks at 0 whenever the sweep is not running, so a new
  // sweep always begins at address 0.
  always_comb begin
    ptr_d = ptr_q + ADDR_W'(1);
    if (!active || restart || last) begin
      ptr_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr  = ptr_q;
  assign done = active & last;

endmodule

// File: rtl/bit_array_ctrl.sv
// Controller / arbiter for a DEPTH x 1-bit masked SRAM (one sync read port,
// one write port, 1-cycle read latency).
//   clock, reset        : clock and asynchronous active-high reset
//   flush               : pulse, clears the whole array
//   init_done           : array is clear and requests are accepted
//   w0_* / w1_*         : write requesters, w0 has fixed priority over w1
//   r_* / resp_*        : read request and held, pulsed response (2-cycle latency)
//   ram_r_* / ram_w_*   : array R0 and W0 port signals
//
// Handshake: a request transfers in a cycle where valid and ready are both
// high. ready never depends on the same requester's valid; w1_ready depends
// on w0_valid only, because w0 wins the single write port.
module bit_array_ctrl
  import bit_array_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  output logic              init_done,
  input  logic              w0_valid,
  output logic              w0_ready,
  input  logic [ADDR_W-1:0] w0_addr,
  input  logic              w0_data,
  input  logic              w1_valid,
  output logic              w1_ready,
  input  logic [ADDR_W-1:0] w1_addr,
  input  logic              w1_data,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              resp_valid,
  output logic              resp_data,
  output logic              ram_r_en,
  output logic [ADDR_W-1:0] ram_r_addr,
  input  logic              ram_r_data,
  output logic              ram_w_en,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic              ram_w_data,
  output logic              ram_w_mask
);

  state_e            state_q, state_d;
  logic              sweep_active;
  logic              sweep_done;
  logic [ADDR_W-1:0] sweep_ptr;

  wr_req_t           w0_req, w1_req, w_sel;
  logic              r_fire;

  logic              resp_pending_q, resp_pending_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_data_q, resp_data_d;
  // Same-cycle read/write collision: remember the written bit so the
  // response is write-first whatever the array does on a collision.
  logic              fwd_hit_q, fwd_hit_d;
  logic              fwd_data_q, fwd_data_d;

  assign sweep_active = (state_q == CLEAR);

  bit_array_sweep #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_sweep (
    .clock   (clock),
    .reset   (reset),
    .active  (sweep_active),
    .restart (flush),
    .ptr     (sweep_ptr),
    .done    (sweep_done)
  );

  // FSM next state. flush wins over sweep completion, so a flush on the
  // last clear cycle starts another full sweep.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (!flush && sweep_done) state_d = IDLE;
      IDLE:    if (flush) state_d = CLEAR;
      default: state_d = CLEAR;
    endcase
  end

  // Write arbitration, read issue and response pipeline.
  always_comb begin
    w0_req.valid = w0_valid;
    w0_req.addr  = w0_addr;
    w0_req.data  = w0_data;
    w1_req.valid = w1_valid;
    w1_req.addr  = w1_addr;
    w1_req.data  = w1_data;
    w_sel        = w0_req.valid ? w0_req : w1_req;

    init_done = (state_q == IDLE);
    w0_ready  = init_done;
    w1_ready  = init_done & ~w0_valid;
    r_ready   = init_done;

    if (init_done) begin
      ram_w_en   = w_sel.valid;
      ram_w_addr = w_sel.addr;
      ram_w_data = w_sel.data;
    end else begin
      ram_w_en   = 1'b1;
      ram_w_addr = sweep_ptr;
      ram_w_data = 1'b0;
    end
    ram_w_mask = ram_w_en;

    r_fire     = r_valid & r_ready;
    ram_r_en   = r_fire;
    ram_r_addr = r_fire ? r_addr : '0;

    resp_pending_d = r_fire;
    fwd_hit_d      = r_fire & ram_w_en & (ram_w_addr == r_addr);
    fwd_data_d     = ram_w_data;

    resp_valid_d = resp_pending_q;
    resp_data_d  = resp_data_q;
    if (resp_pending_q) begin
      resp_data_d = fwd_hit_q ? fwd_data_q : ram_r_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= CLEAR;
      resp_pending_q <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_data_q    <= 1'b0;
      fwd_hit_q      <= 1'b0;
      fwd_data_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      resp_pending_q <= resp_pending_d;
      resp_valid_q   <= resp_valid_d;
      resp_data_q    <= resp_data_d;
      fwd_hit_q      <= fwd_hit_d;
      fwd_data_q     <= fwd_data_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_bit_array_ctrl.sv
// Directed bench for bit_array_ctrl with a read-first array model.
module tb_bit_array_ctrl;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              flush;
  logic              init_done;
  logic              w0_valid, w0_ready, w0_data;
  logic [ADDR_W-1:0] w0_addr;
  logic              w1_valid, w1_ready, w1_data;
  logic [ADDR_W-1:0] w1_addr;
  logic              r_valid, r_ready;
  logic [ADDR_W-1:0] r_addr;
  logic              resp_valid, resp_data;
  logic              ram_r_en;
  logic [ADDR_W-1:0] ram_r_addr;
  logic              ram_r_data;
  logic              ram_w_en;
  logic [ADDR_W-1:0] ram_w_addr;
  logic              ram_w_data, ram_w_mask;

  int n_cmp = 0;
  int n_err = 0;
  logic [0:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  bit_array_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .init_done  (init_done),
    .w0_valid   (w0_valid),
    .w0_ready   (w0_ready),
    .w0_addr    (w0_addr),
    .w0_data    (w0_data),
    .w1_valid   (w1_valid),
    .w1_ready   (w1_ready),
    .w1_addr    (w1_addr),
    .w1_data    (w1_data),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .r_addr     (r_addr),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .ram_r_en   (ram_r_en),
    .ram_r_addr (ram_r_addr),
    .ram_r_data (ram_r_data),
    .ram_w_en   (ram_w_en),
    .ram_w_addr (ram_w_addr),
    .ram_w_data (ram_w_data),
    .ram_w_mask (ram_w_mask)
  );

  // Array model: read data latched before the same-edge write lands.
  logic mem [DEPTH];
  logic rd_q;
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 1'($urandom_range(0, 1));
    rd_q = 1'b0;
  end
  always @(posedge clock) begin
    if (ram_r_en) rd_q <= mem[ram_r_addr];
    if (ram_w_en && ram_w_mask) mem[ram_w_addr] <= ram_w_data;
  end
  assign ram_r_data = rd_q;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Response scoreboard.
  always @(negedge clock) begin
    if (!reset && resp_valid) begin
      if (exp_q.size() == 0) check_eq("resp_unexpected", 32'(resp_valid), 0);
      else check_eq("resp_data", 32'(resp_data), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    flush = 0; w0_valid = 0; w1_valid = 0; r_valid = 0;
    w0_addr = '0; w1_addr = '0; r_addr = '0; w0_data = 0; w1_data = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Full sweep with requests asserted; optional flush at cycle restart_at.
  task automatic check_sweep(input int restart_at);
    int exp_ptr = 0;
    int total = (restart_at < 0) ? DEPTH : restart_at + 1 + DEPTH;
    for (int n = 0; n < total; n++) begin
      w0_valid = n[0]; w1_valid = 1; r_valid = 1;
      w0_addr = 8'hAA; w1_addr = 8'hAA; r_addr = 8'hAA; w0_data = 1; w1_data = 1;
      flush = (n == restart_at);
      #1;
      check_eq("sweep_ctl", 32'({ram_w_en, ram_w_data, ram_w_mask, w0_ready,
                                 w1_ready, r_ready, init_done, ram_r_en}), 32'h0000_00A0);
      check_eq("sweep_addr", 32'(ram_w_addr), 32'(exp_ptr));
      @(negedge clock);
      exp_ptr = (n == restart_at) ? 0 : exp_ptr + 1;
    end
    idle_inputs();
    #1;
    check_eq("init_done_after_sweep", 32'(init_done), 1);
    check_eq("idle_no_write", 32'(ram_w_en), 0);
    check_eq("idle_r_addr_zero", 32'({ram_r_en, ram_r_addr}), 0);
  endtask

  task automatic wr(input int port, input logic [ADDR_W-1:0] a, input logic d);
    if (port == 0) begin w0_valid = 1; w0_addr = a; w0_data = d; end
    else begin w1_valid = 1; w1_addr = a; w1_data = d; end
    #1;
    check_eq("wr_ready", 32'(port == 0 ? w0_ready : w1_ready), 1);
    check_eq("wr_port", 32'({ram_w_en, ram_w_mask, ram_w_data, ram_w_addr}), 32'({2'b11, d, a}));
    @(negedge clock);
    w0_valid = 0; w1_valid = 0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic exp, input bit push);
    r_valid = 1; r_addr = a;
    #1;
    check_eq("rd_issue", 32'({r_ready, ram_r_en, ram_r_addr}), 32'({2'b11, a}));
    if (push) exp_q.push_back(exp);
    @(negedge clock);
    r_valid = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    reset = 1;
    idle(3);
    #1;
    check_eq("reset_vals", 32'({init_done, resp_valid, resp_data, ram_w_addr}), 0);
    reset = 0;
    check_sweep(-1);

    // Cleared array reads back zero, back-to-back.
    rd(8'h00, 0, 1); rd(8'h7F, 0, 1); rd(8'hFF, 0, 1);
    idle(3);

    // w1 write then read with latency check.
    wr(1, 8'h3C, 1);
    rd(8'h3C, 1, 1);
    #1 check_eq("lat_c1_no_resp", 32'(resp_valid), 0);
    @(negedge clock);
    #1 check_eq("lat_c2_resp", 32'({resp_valid, resp_data}), 32'h3);
    @(negedge clock);

    // Both writers valid: w0 wins, w1 waits a cycle.
    w0_valid = 1; w0_addr = 8'h10; w0_data = 1;
    w1_valid = 1; w1_addr = 8'h20; w1_data = 1;
    #1;
    check_eq("arb_readies", 32'({w0_ready, w1_ready}), 32'h2);
    check_eq("arb_w0_sel", 32'({ram_w_en, ram_w_data, ram_w_addr}), 32'h310);
    @(negedge clock);
    w0_valid = 0;
    #1;
    check_eq("arb_w1_ready", 32'(w1_ready), 1);
    check_eq("arb_w1_sel", 32'({ram_w_en, ram_w_data, ram_w_addr}), 32'h320);
    @(negedge clock);
    w1_valid = 0;
    rd(8'h10, 1, 1); rd(8'h20, 1, 1);
    idle(3);

    // Same-cycle write and read of 0x55: write-first.
    w0_valid = 1; w0_addr = 8'h55; w0_data = 1;
    rd(8'h55, 1, 1);
    w0_valid = 0;
    @(negedge clock);
    #1 check_eq("wf_resp", 32'({resp_valid, resp_data}), 32'h3);
    wr(1, 8'h55, 0);
    idle(3);
    #1 check_eq("resp_held", 32'({resp_valid, resp_data}), 32'h1);
    rd(8'h55, 0, 1);
    idle(3);

    // Fill 0x00-0x0F, flush with a read and a write in the flush cycle,
    // then a second flush mid-sweep restarts it.
    for (int i = 0; i < 16; i++) wr(i % 2, 8'(i), 1);
    idle(20);
    flush = 1; r_valid = 1; r_addr = 8'h05;
    w0_valid = 1; w0_addr = 8'h80; w0_data = 1;
    #1;
    check_eq("flush_cycle_accept", 32'({init_done, r_ready, w0_ready, ram_w_en, ram_w_addr}), 32'hF80);
    exp_q.push_back(1'b1);
    @(negedge clock);
    idle_inputs();
    check_sweep(20);
    for (int i = 0; i < 16; i++) rd(8'(i), 0, 1);
    rd(8'h80, 0, 1);
    idle(3);

    // Reset while a read is pending: response dropped.
    rd(8'h07, 0, 0);
    reset = 1;
    #1 check_eq("rst_mid_read", 32'({resp_valid, init_done, ram_w_en, ram_w_addr}), 32'h100);
    idle(2);
    #1 check_eq("resp_dropped", 32'(resp_valid), 0);
    reset = 0;
    check_sweep(-1);

    // Reset at sweep_ptr == 100.
    flush = 1;
    @(negedge clock);
    flush = 0;
    idle(100);
    #1 check_eq("ptr_at_100", 32'(ram_w_addr), 100);
    reset = 1;
    #1 check_eq("rst_mid_sweep", 32'({init_done, ram_w_addr}), 0);
    idle(2);
    reset = 0;
    check_sweep(-1);
    rd(8'h64, 0, 1);
    idle(4);

    check_eq("exp_q_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    check_eq("timeout", 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
